// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states and the
// select codes driven onto the datapath muxes.
package riscv_ctrl_pkg;

  // Major opcodes (IR[6:0]) handled by the multicycle core.
  localparam logic [6:0] OpcLw   = 7'b0000011;
  localparam logic [6:0] OpcSw   = 7'b0100011;
  localparam logic [6:0] OpcR    = 7'b0110011;
  localparam logic [6:0] OpcI    = 7'b0010011;
  localparam logic [6:0] OpcBeq  = 7'b1100011;
  localparam logic [6:0] OpcJal  = 7'b1101111;

  // State encodings are visible on state_o, so the values are fixed explicitly.
  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBeq      = 4'd9,
    StJal      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  // Immediate extender select.
  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  // Result mux select.
  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  // ALU operand A select.
  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  // ALU operand B select.
  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  // ALUOp codes consumed by the separate ALU decoder.
  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_imm_src_dec.sv
// Immediate format select derived purely from the opcode; independent of FSM state.
module imm_src_dec
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] ImmSrc
);

  // Map each opcode to the immediate layout it carries; unknown opcodes fall back to I-type.
  always_comb begin
    ImmSrc = ImmI;
    case (op)
      OpcLw:   ImmSrc = ImmI;
      OpcI:    ImmSrc = ImmI;
      OpcSw:   ImmSrc = ImmS;
      OpcBeq:  ImmSrc = ImmB;
      OpcJal:  ImmSrc = ImmJ;
      default: ImmSrc = ImmI;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core. Sequences fetch/decode/execute over the shared
// datapath, stalls on the memory handshake and counts retired instructions.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ImmSrc,
  output logic             illegal_op,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             illegal_q;

  // Raw enables before the reset gate.
  logic pc_update;
  logic branch;
  logic ir_write_raw;
  logic reg_write_raw;
  logic mem_write_raw;
  logic retire;

  imm_src_dec u_imm_src_dec (
    .op     (op),
    .ImmSrc (ImmSrc)
  );

  // Next-state and Moore datapath controls; everything defaults to 0 / hold.
  always_comb begin
    state_d       = state_q;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    retire        = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = ResAluOut;
    ALUSrcA       = SrcAPc;
    ALUSrcB       = SrcBRs2;
    ALUOp         = AluAdd;

    unique case (state_q)
      StFetch: begin
        // PC+4 is computed and written in the same cycle the IR is loaded.
        ALUSrcA      = SrcAPc;
        ALUSrcB      = SrcBFour;
        ALUOp        = AluAdd;
        ResultSrc    = ResAluResult;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
        if (mem_ready) begin
          state_d = StDecode;
        end
      end
      StDecode: begin
        // Speculatively compute the branch/jump target into ALUOut.
        ALUSrcA = SrcAOldPc;
        ALUSrcB = SrcBImm;
        case (op)
          OpcLw, OpcSw: state_d = StMemAdr;
          OpcR:         state_d = StExecR;
          OpcI:         state_d = StExecI;
          OpcBeq:       state_d = StBeq;
          OpcJal:       state_d = StJal;
          default:      state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        if (op == OpcLw) begin
          state_d = StMemRead;
        end else if (op == OpcSw) begin
          state_d = StMemWrite;
        end else begin
          state_d = StTrap;
        end
      end
      StMemRead: begin
        AdrSrc = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end
      end
      StMemWb: begin
        ResultSrc     = ResData;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StMemWrite: begin
        // Write strobe held until memory accepts it.
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExecR: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBRs2;
        ALUOp   = AluFunct;
        state_d = StAluWb;
      end
      StExecI: begin
        ALUSrcA = SrcARs1;
        ALUSrcB = SrcBImm;
        ALUOp   = AluFunct;
        state_d = StAluWb;
      end
      StAluWb: begin
        ResultSrc     = ResAluOut;
        reg_write_raw = 1'b1;
        retire        = 1'b1;
        state_d       = StFetch;
      end
      StBeq: begin
        // Compare rs1-rs2; PC takes the target held in ALUOut when Zero.
        ALUSrcA   = SrcARs1;
        ALUSrcB   = SrcBRs2;
        ALUOp     = AluSub;
        ResultSrc = ResAluOut;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = StFetch;
      end
      StJal: begin
        // PC <- target from ALUOut while ALU forms OldPC+4 for the link write in ALUWB.
        ALUSrcA   = SrcAOldPc;
        ALUSrcB   = SrcBFour;
        ResultSrc = ResAluOut;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // State, retired counter and sticky illegal flag; synchronous reset has priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
      if (state_d == StTrap) begin
        illegal_q <= 1'b1;
      end
    end
  end

  // Architectural write enables are suppressed while reset is asserted.
  always_comb begin
    PCWrite  = ~rst & (pc_update | (branch & Zero));
    IRWrite  = ~rst & ir_write_raw;
    RegWrite = ~rst & reg_write_raw;
    MemWrite = ~rst & mem_write_raw;
  end

  assign illegal_op = illegal_q;
  assign state_o    = state_q;
  assign retired    = retired_q;

endmodule
